sram_arbiter: RTL

Two-master arbiter in front of the data-memory SRAM model. Accepts AXI-lite-style read requests from the IFU and read/write requests from the LSU, serialises them onto the SRAM's level-held `ren`/`wen` request interface, and registers each SRAM response back to the master that issued it. One transaction is in flight at a time; grant alternates round-robin between IFU and LSU.

---
 rtl/sram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-master (IFU read, LSU read/write) round-robin arbiter in front of a
// level-request SRAM model; one transaction in flight at a time.
module sram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // IFU read channel
  input  logic                    ifu_arvalid,
  output logic                    ifu_arready,
  input  logic [ADDR_WIDTH-1:0]   ifu_araddr,
  output logic                    ifu_rvalid,
  input  logic                    ifu_rready,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  output logic [1:0]              ifu_rresp,
  // LSU read channel
  input  logic                    lsu_arvalid,
  output logic                    lsu_arready,
  input  logic [ADDR_WIDTH-1:0]   lsu_araddr,
  output logic                    lsu_rvalid,
  input  logic                    lsu_rready,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic [1:0]              lsu_rresp,
  // LSU write channels
  input  logic                    lsu_awvalid,
  output logic                    lsu_awready,
  input  logic [ADDR_WIDTH-1:0]   lsu_awaddr,
  input  logic                    lsu_wvalid,
  output logic                    lsu_wready,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
  output logic                    lsu_bvalid,
  input  logic                    lsu_bready,
  output logic [1:0]              lsu_bresp,
  // SRAM side
  output logic [ADDR_WIDTH-1:0]   sram_araddr,
  output logic                    sram_ren,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  input  logic [1:0]              sram_rresp,
  input  logic                    sram_rvalid,
  output logic [ADDR_WIDTH-1:0]   sram_awaddr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_wstrb,
  output logic                    sram_wen,
  input  logic [1:0]              sram_bresp,
  input  logic                    sram_bvalid
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, IFU_RD, LSU_RD, LSU_WR, IFU_RSP, LSU_RSP, LSU_BRSP
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_lsu_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [DATA_WIDTH-1:0]   ifu_rdata_q, lsu_rdata_q;
  logic [1:0]              ifu_rresp_q, lsu_rresp_q, lsu_bresp_q;
  logic                    lsu_wr_req, lsu_req;

  assign lsu_wr_req = lsu_awvalid && lsu_wvalid;
  assign lsu_req    = lsu_wr_req || lsu_arvalid;

  assign sram_araddr = addr_q;
  assign sram_awaddr = addr_q;
  assign sram_wdata  = wdata_q;
  assign sram_wstrb  = wstrb_q;
  assign ifu_rdata   = ifu_rdata_q;
  assign ifu_rresp   = ifu_rresp_q;
  assign lsu_rdata   = lsu_rdata_q;
  assign lsu_rresp   = lsu_rresp_q;
  assign lsu_bresp   = lsu_bresp_q;

  // Next state, grant and SRAM request decode
  always_comb begin
    state_d     = state_q;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_bvalid  = 1'b0;
    sram_ren    = 1'b0;
    sram_wen    = 1'b0;
    case (state_q)
      IDLE: begin
        // Readies are gated by reset so nothing is granted while it is held
        if (rst) begin
          if (ifu_arvalid && (!lsu_req || last_lsu_q)) begin
            ifu_arready = 1'b1;
            state_d     = IFU_RD;
          end else if (lsu_wr_req) begin
            lsu_awready = 1'b1;
            lsu_wready  = 1'b1;
            state_d     = LSU_WR;
          end else if (lsu_arvalid) begin
            lsu_arready = 1'b1;
            state_d     = LSU_RD;
          end
        end
      end
      IFU_RD: begin
        sram_ren = !sram_rvalid;
        if (sram_rvalid) state_d = IFU_RSP;
      end
      LSU_RD: begin
        sram_ren = !sram_rvalid;
        if (sram_rvalid) state_d = LSU_RSP;
      end
      LSU_WR: begin
        sram_wen = !sram_bvalid;
        if (sram_bvalid) state_d = LSU_BRSP;
      end
      IFU_RSP: begin
        ifu_rvalid = 1'b1;
        if (ifu_rready) state_d = IDLE;
      end
      LSU_RSP: begin
        lsu_rvalid = 1'b1;
        if (lsu_rready) state_d = IDLE;
      end
      LSU_BRSP: begin
        lsu_bvalid = 1'b1;
        if (lsu_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin flag and payload/response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_lsu_q  <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ifu_rdata_q <= '0;
      ifu_rresp_q <= '0;
      lsu_rdata_q <= '0;
      lsu_rresp_q <= '0;
      lsu_bresp_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ifu_arready) begin
            addr_q     <= ifu_araddr;
            last_lsu_q <= 1'b0;
          end else if (lsu_awready) begin
            addr_q     <= lsu_awaddr;
            wdata_q    <= lsu_wdata;
            wstrb_q    <= lsu_wstrb;
            last_lsu_q <= 1'b1;
          end else if (lsu_arready) begin
            addr_q     <= lsu_araddr;
            last_lsu_q <= 1'b1;
          end
        end
        IFU_RD: if (sram_rvalid) begin
          ifu_rdata_q <= sram_rdata;
          ifu_rresp_q <= sram_rresp;
        end
        LSU_RD: if (sram_rvalid) begin
          lsu_rdata_q <= sram_rdata;
          lsu_rresp_q <= sram_rresp;
        end
        LSU_WR: if (sram_bvalid) lsu_bresp_q <= sram_bresp;
        default: ;
      endcase
    end
  end

endmodule
